// File: rtl/ge_prog_exec.sv
// Sequential interpreter for 4-register GE straight-line programs.
// Buffers an instruction stream, then executes one instruction per cycle on sampled operands.
module ge_prog_exec #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b0,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [7:0]       ins_data,
    input  logic             ins_last,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             rerun,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y0,
    output logic             err
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LEN_FULL = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [LW-1:0]    len_q;
    logic [AW-1:0]    pc_q;
    logic [WIDTH-1:0] r_q    [4];
    logic [WIDTH-1:0] opnd_q [4];
    logic [7:1]       prog_q [MAX_LEN];
    logic             ins_ready_q;
    logic             out_valid_q;
    logic             err_q;

    logic             beat_c;
    logic             start_c;
    logic             last_pc_c;
    logic [AW-1:0]    wr_idx_c;
    logic [1:0]       op_c;
    logic [1:0]       dst_idx_c;
    logic             src_in_c;
    logic [1:0]       src_idx_c;
    logic [WIDTH-1:0] src_c;
    logic [WIDTH-1:0] dst_c;
    logic [WIDTH-1:0] res_c;
    logic             unused_rsvd_c;

    // Bit 0 of an instruction is reserved and never stored.
    assign unused_rsvd_c = ins_data[0];

    // Handshake qualifiers and decode/execute of the instruction at pc.
    always_comb begin
        beat_c    = ins_valid & ins_ready_q;
        start_c   = (beat_c & ins_last) | ((state_q == S_DONE) & out_ready & rerun);
        last_pc_c = ({1'b0, pc_q} == (len_q - LW'(1)));
        wr_idx_c  = (state_q == S_IDLE) ? '0 : len_q[AW-1:0];

        op_c      = prog_q[pc_q][7:6];
        dst_idx_c = prog_q[pc_q][5:4];
        src_in_c  = prog_q[pc_q][3];
        src_idx_c = prog_q[pc_q][2:1];

        src_c = src_in_c ? opnd_q[src_idx_c] : r_q[src_idx_c];
        dst_c = r_q[dst_idx_c];
        res_c = '0;
        unique case (op_c)
            2'b00: res_c = dst_c & src_c;
            2'b01: res_c = dst_c | src_c;
            2'b10: res_c = dst_c ^ src_c;
            2'b11: res_c = (src_c == '0) ? WIDTH'(1) : '0;
            default: res_c = '0;
        endcase
    end

    // Instruction buffer; not reset, overflow beats are discarded.
    always_ff @(posedge clk) begin
        if (beat_c && ((state_q == S_IDLE) || (len_q < LEN_FULL))) begin
            prog_q[wr_idx_c] <= ins_data[7:1];
        end
    end

    // Control FSM, register file and operand copies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            pc_q        <= '0;
            ins_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_q[i]    <= '0;
                opnd_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ins_ready_q <= 1'b1;
                    if (beat_c) begin
                        err_q   <= 1'b0;
                        len_q   <= LW'(1);
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (beat_c) begin
                        if (len_q == LEN_FULL) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q <= len_q + LW'(1);
                        end
                    end
                end
                S_RUN: begin
                    r_q[dst_idx_c] <= res_c;
                    if (last_pc_c) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        pc_q <= pc_q + AW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        ins_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Run start (last beat or rerun) overrides the per-state updates above.
            if (start_c) begin
                state_q     <= S_RUN;
                ins_ready_q <= 1'b0;
                out_valid_q <= 1'b0;
                pc_q        <= '0;
                opnd_q[0]   <= a0;
                opnd_q[1]   <= a1;
                opnd_q[2]   <= b0;
                opnd_q[3]   <= b1;
                r_q[0]      <= a0;
                r_q[1]      <= a1;
                r_q[2]      <= b0;
                r_q[3]      <= b1;
            end
        end
    end

    assign ins_ready = ins_ready_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign y0        = r_q[0];
    assign y1        = r_q[1];
    assign y2        = r_q[2];
    assign y3        = r_q[3];

endmodule

// File: tb/tb_ge_prog_exec.sv
// Self-checking bench for ge_prog_exec: directed cases plus random programs
// compared against a behavioural program interpreter.
module tb_ge_prog_exec;

    localparam int unsigned W  = 16;
    localparam int unsigned ML = 8;

    typedef logic [3:0][W-1:0] quad_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a0, a1, b0, b1;
    logic         ins_valid, ins_ready, ins_last;
    logic [7:0]   ins_data;
    logic         out_valid, out_ready, rerun;
    logic [W-1:0] y0, y1, y2, y3;
    logic         err;

    ge_prog_exec #(.WIDTH(W), .MAX_LEN(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a1        (a1),
        .a0        (a0),
        .b1        (b1),
        .b0        (b0),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_data  (ins_data),
        .ins_last  (ins_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rerun     (rerun),
        .y3        (y3),
        .y2        (y2),
        .y1        (y1),
        .y0        (y0),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk;
    int         n_err;
    logic [7:0] prog[$];
    quad_t      run_ops;
    logic       exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Interpret the buffered program: registers start as the operands, at most ML instructions run.
    function automatic quad_t model(input quad_t ops);
        quad_t      r;
        int         n;
        logic [7:0] ins;
        logic [W-1:0] s;
        r = ops;
        n = (prog.size() < ML) ? prog.size() : ML;
        for (int i = 0; i < n; i++) begin
            ins = prog[i];
            s   = ins[3] ? ops[ins[2:1]] : r[ins[2:1]];
            case (ins[7:6])
                2'd0: r[ins[5:4]] = r[ins[5:4]] & s;
                2'd1: r[ins[5:4]] = r[ins[5:4]] | s;
                2'd2: r[ins[5:4]] = r[ins[5:4]] ^ s;
                default: r[ins[5:4]] = (s == 0) ? W'(1) : W'(0);
            endcase
        end
        return r;
    endfunction

    function automatic quad_t rand_ops();
        quad_t o;
        for (int i = 0; i < 4; i++) begin
            o[i] = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
        end
        return o;
    endfunction

    task automatic set_ports(input quad_t o);
        a0 = o[0];
        a1 = o[1];
        b0 = o[2];
        b1 = o[3];
    endtask

    task automatic send_prog(input quad_t ops);
        int guard;
        set_ports(ops);
        for (int i = 0; i < prog.size(); i++) begin
            ins_data  = prog[i];
            ins_valid = 1'b1;
            ins_last  = (i == prog.size() - 1);
            guard = 0;
            while (!ins_ready && guard < 50) begin
                step();
                guard++;
            end
            if (guard == 50) check("ins_ready_timeout", 32'(ins_ready), 32'd1);
            step();
        end
        ins_valid = 1'b0;
        ins_last  = 1'b0;
        ins_data  = 8'h00;
        run_ops   = ops;
        exp_err   = (prog.size() > ML);
    endtask

    // Wait for the result, scrambling live operands meanwhile, then compare to the model.
    task automatic wait_result(input string tag);
        int    cnt;
        int    n_exp;
        logic  rdy_seen;
        quad_t exp;
        n_exp    = (prog.size() < ML) ? prog.size() : ML;
        cnt      = 0;
        rdy_seen = 1'b0;
        set_ports(rand_ops());
        while (!out_valid && cnt < 100) begin
            rdy_seen |= ins_ready;
            step();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(n_exp));
        check({tag, "_ready_in_run"}, 32'(rdy_seen | ins_ready), 32'd0);
        exp = model(run_ops);
        check({tag, "_y0"}, 32'(y0), 32'(exp[0]));
        check({tag, "_y1"}, 32'(y1), 32'(exp[1]));
        check({tag, "_y2"}, 32'(y2), 32'(exp[2]));
        check({tag, "_y3"}, 32'(y3), 32'(exp[3]));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic accept(input logic do_rerun, input quad_t ops, input string tag);
        set_ports(ops);
        out_ready = 1'b1;
        rerun     = do_rerun;
        step();
        out_ready = 1'b0;
        rerun     = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        if (do_rerun) begin
            run_ops = ops;
            wait_result({tag, "_rerun"});
        end else begin
            check({tag, "_ready_idle"}, 32'(ins_ready), 32'd1);
        end
    endtask

    initial begin
        quad_t        o;
        logic [W-1:0] h0, h1, h2, h3;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        ins_valid = 1'b0;
        ins_last  = 1'b0;
        ins_data  = 8'h00;
        out_ready = 1'b0;
        rerun     = 1'b0;
        set_ports('0);

        // Reset state
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ins_ready", 32'(ins_ready), 32'd0);
        check("rst_y", 32'({y3, y2, y1, y0} != 0), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(ins_ready), 32'd1);

        // r0 ^= a1, then rerun with a1 = 0xFFFF
        prog = '{8'h8A};
        o = '0;
        o[0] = 16'h00F0;
        o[1] = 16'h0F0F;
        send_prog(o);
        wait_result("xor");
        check("xor_y0_const", 32'(y0), 32'h0FFF);
        check("xor_y1_const", 32'(y1), 32'h0F0F);
        o[1] = 16'hFFFF;
        accept(1'b1, o, "xor");
        check("rerun_y0_const", 32'(y0), 32'hFF0F);
        accept(1'b0, o, "xor2");

        // r2 = !r2 with b0 zero and nonzero
        prog = '{8'hE4};
        o = '0;
        send_prog(o);
        wait_result("not0");
        check("not0_y2_const", 32'(y2), 32'h0001);
        accept(1'b0, o, "not0");
        o[2] = 16'h0005;
        send_prog(o);
        wait_result("not5");
        check("not5_y2_const", 32'(y2), 32'h0000);
        accept(1'b0, o, "not5");

        // r3 ^= r3; r3 |= b0 (live b0 scrambled during run)
        prog = '{8'hB6, 8'h7C};
        o = '0;
        o[2] = 16'h1234;
        o[3] = 16'hFFFF;
        send_prog(o);
        wait_result("clr_or");
        check("clr_or_y3_const", 32'(y3), 32'h1234);
        accept(1'b0, o, "clr_or");

        // Overflow: ML+2 beats, only ML execute, err sticky across hold
        prog.delete();
        for (int i = 0; i < ML + 2; i++) prog.push_back(8'h4A);
        o = rand_ops();
        send_prog(o);
        wait_result("ovf");
        check("ovf_err_const", 32'(err), 32'd1);
        h0 = y0; h1 = y1; h2 = y2; h3 = y3;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", 32'({y3, y2, y1, y0} == {h3, h2, h1, h0}), 32'd1);
        end
        accept(1'b0, o, "ovf");
        prog = '{8'h8A};
        send_prog(rand_ops());
        wait_result("after_ovf");
        accept(1'b0, o, "after_ovf");

        // Random programs with random reruns
        for (int t = 0; t < 40; t++) begin
            prog.delete();
            for (int i = 0; i < int'($urandom_range(1, ML + 4)); i++) prog.push_back(8'($urandom));
            send_prog(rand_ops());
            wait_result("rnd");
            if ($urandom_range(0, 1) == 1) accept(1'b1, rand_ops(), "rnd");
            accept(1'b0, rand_ops(), "rnd_end");
        end

        // Reset in the middle of a run
        prog.delete();
        for (int i = 0; i < 6; i++) prog.push_back(8'($urandom));
        send_prog(rand_ops());
        step();
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y", 32'({y3, y2, y1, y0} != 0), 32'd0);
        check("midrst_ready", 32'(ins_ready), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();
        check("midrst_ready_after", 32'(ins_ready), 32'd1);
        prog = '{8'h8A, 8'h1E};
        send_prog(rand_ops());
        wait_result("recover");
        accept(1'b0, '0, "recover");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
